// File: rtl/reg_file_dumper_pkg.sv
// Shared constants and FSM encoding for the register-file dump engine.
// The geometry matches the 9-bit, 4-entry processor register file.
package reg_file_dumper_pkg;

  localparam int DATA_W = 9;
  localparam int ADDR_W = 2;
  localparam int NREGS  = 4;
  localparam int IDX_W  = ADDR_W + 1;

  // out_idx value that tags the checksum word (one past the last register)
  localparam logic [IDX_W-1:0] CHK_IDX = IDX_W'(NREGS);

  // Last address walked; the dump finishes after this register is handed off
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_SEND = 3'd2,
    ST_SUM  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/reg_file_dumper.sv
// Debug read-out engine on a spare register-file read port.
// A start pulse in IDLE walks addresses 0..NREGS-1, snapshots each register
// and streams it out on a valid/ready interface tagged with its index.
// Optional checksum word enabled by defining REG_FILE_DUMPER_CHKSUM_EN:
// after the last register an extra word (idx = NREGS) carries the modulo
// 2**DATA_W sum of all captured words.
// Every output is driven straight from a flop; out_ready only steers the
// next-state logic.
module reg_file_dumper
  import reg_file_dumper_pkg::*;
(
  input  logic              clk,
  input  logic              rst,        // asynchronous, active low
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx
);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_busy;
  logic                w_busy_next;
  logic                r_done;
  logic                w_done_next;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [ADDR_W-1:0]   w_rd_addr_next;
  logic                r_out_valid;
  logic                w_out_valid_next;
  logic [DATA_W-1:0]   r_out_data;
  logic [DATA_W-1:0]   w_out_data_next;
  logic [IDX_W-1:0]    r_out_idx;
  logic [IDX_W-1:0]    w_out_idx_next;
  logic                w_handshake;

`ifdef REG_FILE_DUMPER_CHKSUM_EN
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   w_acc_next;
`endif

  assign w_handshake = r_out_valid && out_ready;

  // Next-state and next-output decode; every register holds by default
  always_comb begin
    w_state_next     = r_state;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;
    w_rd_addr_next   = r_rd_addr;
    w_out_valid_next = r_out_valid;
    w_out_data_next  = r_out_data;
    w_out_idx_next   = r_out_idx;
`ifdef REG_FILE_DUMPER_CHKSUM_EN
    w_acc_next       = r_acc;
`endif

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_rd_addr_next = '0;
          w_busy_next    = 1'b1;
`ifdef REG_FILE_DUMPER_CHKSUM_EN
          w_acc_next     = '0;
`endif
          w_state_next   = ST_READ;
        end
      end

      // Snapshot the register at this edge; later writes are not seen
      ST_READ: begin
        w_out_data_next  = rd_data;
        w_out_idx_next   = {1'b0, r_rd_addr};
        w_out_valid_next = 1'b1;
`ifdef REG_FILE_DUMPER_CHKSUM_EN
        w_acc_next       = r_acc + rd_data;
`endif
        w_state_next     = ST_SEND;
      end

      // Hold the word until the consumer takes it
      ST_SEND: begin
        if (w_handshake) begin
          w_out_valid_next = 1'b0;
          if (r_rd_addr == LAST_ADDR) begin
`ifdef REG_FILE_DUMPER_CHKSUM_EN
            w_state_next = ST_SUM;
`else
            w_done_next  = 1'b1;
            w_state_next = ST_DONE;
`endif
          end else begin
            w_rd_addr_next = r_rd_addr + ADDR_W'(1);
            w_state_next   = ST_READ;
          end
        end
      end

`ifdef REG_FILE_DUMPER_CHKSUM_EN
      // First cycle loads the checksum word, then wait for its handshake
      ST_SUM: begin
        if (!r_out_valid) begin
          w_out_data_next  = r_acc;
          w_out_idx_next   = CHK_IDX;
          w_out_valid_next = 1'b1;
        end else if (out_ready) begin
          w_out_valid_next = 1'b0;
          w_done_next      = 1'b1;
          w_state_next     = ST_DONE;
        end
      end
`endif

      // done is high for exactly this one cycle; restart is possible next cycle
      ST_DONE: begin
        w_busy_next    = 1'b0;
        w_rd_addr_next = '0;
        w_state_next   = ST_IDLE;
      end

      default: begin
        w_busy_next      = 1'b0;
        w_rd_addr_next   = '0;
        w_out_valid_next = 1'b0;
        w_state_next     = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any dump in progress at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_addr   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_rd_addr   <= w_rd_addr_next;
      r_out_valid <= w_out_valid_next;
      r_out_data  <= w_out_data_next;
      r_out_idx   <= w_out_idx_next;
    end
  end

`ifdef REG_FILE_DUMPER_CHKSUM_EN
  // Running checksum of every word captured in the current dump
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_acc_next;
    end
  end
`endif

  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_addr   = r_rd_addr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;

endmodule

// File: tb/tb_reg_file_dumper.sv
// Directed bench for reg_file_dumper: a behavioural 4-entry register file
// drives rd_data combinationally; each dump is stepped cycle by cycle and
// every output is compared against hand-computed values.
// Checksum word is checked when REG_FILE_DUMPER_CHKSUM_EN is defined.
module tb_reg_file_dumper;
  import reg_file_dumper_pkg::*;

  logic              clk;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] exp_vals [NREGS];

  int n_checks;
  int n_err;
  int done_cnt;

  reg_file_dumper dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx)
  );

  assign rd_data = regs[rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses away from the active edge
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One full dump. Optional: stall ready 5 cycles at word 1, overwrite reg1
  // after word 1 is captured, pulse start while busy.
  task automatic dump(input string name, input bit stall_w1, input bit write_w1,
                      input bit poke_start);
    logic [DATA_W-1:0] sum;
    int                dc0;
    sum = '0;
    for (int i = 0; i < NREGS; i++) sum = sum + exp_vals[i];
    dc0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, ".busy_after_start"}, 32'(busy), 32'd1);
    chk({name, ".valid_after_start"}, 32'(out_valid), 32'd0);
    for (int w = 0; w < NREGS; w++) begin
      tick();
      chk($sformatf("%s.w%0d.valid", name, w), 32'(out_valid), 32'd1);
      chk($sformatf("%s.w%0d.idx", name, w), 32'(out_idx), 32'(w));
      chk($sformatf("%s.w%0d.data", name, w), 32'(out_data), 32'(exp_vals[w]));
      chk($sformatf("%s.w%0d.rd_addr", name, w), 32'(rd_addr), 32'(w));
      if (write_w1 && w == 1) regs[1] = 9'h123;
      if (stall_w1 && w == 1) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          chk($sformatf("%s.stall%0d.valid", name, s), 32'(out_valid), 32'd1);
          chk($sformatf("%s.stall%0d.data", name, s), 32'(out_data), 32'(exp_vals[1]));
          chk($sformatf("%s.stall%0d.idx", name, s), 32'(out_idx), 32'd1);
        end
        out_ready = 1'b1;
      end
      if (poke_start && w == 2) start = 1'b1;
      tick();
      start = 1'b0;
      chk($sformatf("%s.w%0d.valid_drop", name, w), 32'(out_valid), 32'd0);
      chk($sformatf("%s.w%0d.busy", name, w), 32'(busy), 32'd1);
    end
`ifdef REG_FILE_DUMPER_CHKSUM_EN
    chk({name, ".done_early"}, 32'(done), 32'd0);
    tick();
    chk({name, ".sum.valid"}, 32'(out_valid), 32'd1);
    chk({name, ".sum.idx"}, 32'(out_idx), 32'(NREGS));
    chk({name, ".sum.data"}, 32'(out_data), 32'(sum));
    tick();
    chk({name, ".sum.valid_drop"}, 32'(out_valid), 32'd0);
`endif
    chk({name, ".done"}, 32'(done), 32'd1);
    chk({name, ".busy_in_done"}, 32'(busy), 32'd1);
    tick();
    chk({name, ".done_end"}, 32'(done), 32'd0);
    chk({name, ".busy_end"}, 32'(busy), 32'd0);
    chk({name, ".rd_addr_end"}, 32'(rd_addr), 32'd0);
    tick();
    chk({name, ".idle_valid"}, 32'(out_valid), 32'd0);
    chk({name, ".idle_busy"}, 32'(busy), 32'd0);
    chk({name, ".done_count"}, 32'(done_cnt - dc0), 32'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_err     = 0;
    done_cnt  = 0;
    rst       = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    regs[0] = 9'h001; regs[1] = 9'h0FF; regs[2] = 9'h1AA; regs[3] = 9'h155;
    for (int i = 0; i < NREGS; i++) exp_vals[i] = regs[i];

    // Reset state
    #2;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.rd_addr", 32'(rd_addr), 32'd0);
    chk("rst.data", 32'(out_data), 32'd0);
    chk("rst.idx", 32'(out_idx), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("idle.busy", 32'(busy), 32'd0);

    // Plain dump, ready tied high
    dump("basic", 1'b0, 1'b0, 1'b0);

    // Backpressure at word 1
    dump("stall", 1'b1, 1'b0, 1'b0);

    // Overwrite reg1 after its capture: this dump still sees 0FF
    dump("snap", 1'b0, 1'b1, 1'b0);
    chk("snap.reg1_written", 32'(regs[1]), 32'h123);
    exp_vals[1] = 9'h123;
    dump("snap2", 1'b0, 1'b0, 1'b0);

    // start while busy is ignored
    dump("poke", 1'b0, 1'b0, 1'b1);

    // Reset during SEND of word 2
    begin
      int dc0;
      dc0 = done_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      chk("abort.pre.valid", 32'(out_valid), 32'd1);
      chk("abort.pre.idx", 32'(out_idx), 32'd2);
      #3;
      rst = 1'b0;
      #1;
      chk("abort.valid", 32'(out_valid), 32'd0);
      chk("abort.busy", 32'(busy), 32'd0);
      chk("abort.rd_addr", 32'(rd_addr), 32'd0);
      chk("abort.done", 32'(done), 32'd0);
      tick();
      rst = 1'b1;
      tick();
      chk("abort.idle_valid", 32'(out_valid), 32'd0);
      chk("abort.no_done", 32'(done_cnt - dc0), 32'd0);
    end
    dump("after_abort", 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
